gray_decode_check: RTL

GRAY_DECODE_CHECK -- requirements
Module: gray_decode_check

---
 rtl/gray_pkg.sv | 18 +
 rtl/gray_decode_check_if.sv | 25 ++
 rtl/gray2bin.sv | 13 +
 rtl/gray_decode_check.sv | 93 +++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared Gray-code definitions: lock state encoding and a width-agnostic Gray-to-binary decode.
package gray_pkg;

  localparam int unsigned MaxBits = 32;

  typedef enum logic [1:0] {StEmpty, StAcq, StLocked} state_e;

  // Zero-extended input is safe: leading zeros leave the prefix-XOR unchanged.
  function automatic logic [MaxBits-1:0] gray_to_bin(input logic [MaxBits-1:0] g);
    logic [MaxBits-1:0] b;
    b[MaxBits-1] = g[MaxBits-1];
    for (int i = MaxBits - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_decode_check_if.sv
// Sample/result bundle between a Gray counter source and the decode checker.
interface gray_decode_check_if #(
  parameter int unsigned CBITS = 11
);

  logic [CBITS-1:0] gray_in;
  logic             valid_in;
  logic [CBITS-1:0] bin_out;
  logic             bin_valid;
  logic             locked;
  logic             wrap;
  logic             err;
  logic [7:0]       err_cnt;

  modport master (
    output gray_in, valid_in,
    input  bin_out, bin_valid, locked, wrap, err, err_cnt
  );

  modport slave (
    input  gray_in, valid_in,
    output bin_out, bin_valid, locked, wrap, err, err_cnt
  );

endinterface

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter of parameterised width.
module gray2bin
  import gray_pkg::*;
#(
  parameter int unsigned CBITS = 11
) (
  input  logic [CBITS-1:0] gray,
  output logic [CBITS-1:0] bin
);

  assign bin = CBITS'(gray_to_bin(MaxBits'(gray)));

endmodule

// File: rtl/gray_decode_check.sv
// Decodes Gray count samples and tracks lock on a strictly incrementing sequence.
module gray_decode_check
  import gray_pkg::*;
#(
  parameter int unsigned CBITS  = 11,
  parameter int unsigned LOCK_N = 4
) (
  input logic                clk,
  input logic                rst,
  gray_decode_check_if.slave bus
);

  logic [CBITS-1:0] decoded;
  logic [CBITS-1:0] prev_q;
  logic [CBITS-1:0] bin_q;
  logic [3:0]       good_q;
  logic [3:0]       good_inc;
  logic [7:0]       err_cnt_q;
  logic             bin_valid_q, locked_q, wrap_q, err_q;
  logic             is_succ, at_max;
  state_e           state_q;

  gray2bin #(
    .CBITS(CBITS)
  ) u_gray2bin (
    .gray(bus.gray_in),
    .bin (decoded)
  );

  assign is_succ  = (decoded == prev_q + CBITS'(1));
  assign at_max   = (prev_q == '1);
  assign good_inc = good_q + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StEmpty;
      prev_q      <= '0;
      good_q      <= '0;
      bin_q       <= '0;
      bin_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      wrap_q      <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      bin_valid_q <= bus.valid_in;
      wrap_q      <= 1'b0;
      err_q       <= 1'b0;
      if (bus.valid_in) begin
        bin_q  <= decoded;
        prev_q <= decoded;
        unique case (state_q)
          StEmpty: begin
            good_q  <= '0;
            state_q <= StAcq;
          end
          StAcq: begin
            if (is_succ) begin
              good_q <= good_inc;
              if (good_inc == 4'(LOCK_N)) begin
                state_q  <= StLocked;
                locked_q <= 1'b1;
              end
            end else begin
              good_q <= '0;
            end
          end
          StLocked: begin
            if (is_succ) begin
              // Successor from all-ones can only be zero, so this is the wrap.
              wrap_q <= at_max;
            end else begin
              err_q    <= 1'b1;
              locked_q <= 1'b0;
              good_q   <= '0;
              state_q  <= StAcq;
              if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            end
          end
          default: state_q <= StEmpty;
        endcase
      end
    end
  end

  assign bus.bin_out   = bin_q;
  assign bus.bin_valid = bin_valid_q;
  assign bus.locked    = locked_q;
  assign bus.wrap      = wrap_q;
  assign bus.err       = err_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule
